// File: rtl/arc4_prga.sv
// ARC4 pseudo-random generation stage: walks the scheduled S array, swaps entries in place
// and XORs the keystream with the length-prefixed ciphertext into plaintext memory.
module arc4_prga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    StIdle,
    StRdLen,
    StWrLen,
    StIncI,
    StRdSi,
    StRdSj,
    StWrSj,
    StRdPad,
    StXor
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [7:0] len_q, len_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      i_q     <= 8'h00;
      j_q     <= 8'h00;
      k_q     <= 8'h00;
      len_q   <= 8'h00;
      si_q    <= 8'h00;
      sj_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    rdy       = 1'b0;
    s_addr    = 8'h00;
    s_wrdata  = 8'h00;
    s_wren    = 1'b0;
    ct_addr   = 8'h00;
    pt_addr   = 8'h00;
    pt_wrdata = 8'h00;
    pt_wren   = 1'b0;

    unique case (state_q)
      StIdle: begin
        rdy = 1'b1;
        if (en) begin
          i_d     = 8'h00;
          j_d     = 8'h00;
          k_d     = 8'h01;
          state_d = StRdLen;
        end
      end
      StRdLen: begin
        ct_addr = 8'h00;
        state_d = StWrLen;
      end
      StWrLen: begin
        len_d     = ct_rddata;
        pt_addr   = 8'h00;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        state_d   = (ct_rddata == 8'h00) ? StIdle : StIncI;
      end
      StIncI: begin
        i_d     = i_q + 8'h01;
        s_addr  = i_q + 8'h01;
        state_d = StRdSi;
      end
      StRdSi: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        s_addr  = j_q + s_rddata;
        state_d = StRdSj;
      end
      StRdSj: begin
        // S[i] <= S[j]; when i == j both writes carry the same value
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = StWrSj;
      end
      StWrSj: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = StRdPad;
      end
      StRdPad: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
        state_d = StXor;
      end
      StXor: begin
        pt_addr   = k_q;
        pt_wrdata = s_rddata ^ ct_rddata;
        pt_wren   = 1'b1;
        if (k_q == len_q) begin
          state_d = StIdle;
        end else begin
          k_d     = k_q + 8'h01;
          state_d = StIncI;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_arc4_prga.sv
// Self-checking bench for arc4_prga: behavioural memories plus a plain RC4 PRGA reference model.
module tb_arc4_prga;

  logic       clk = 1'b0;
  logic       rst_n, en, rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
  logic       s_wren, pt_wren;

  logic [7:0] s_mem[256], s_init[256], ct_mem[256], pt_mem[256];
  logic [7:0] exp_pt[256], exp_s[256];
  logic       load;
  int         s_wr_cnt, pt_wr_cnt;
  int         vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  arc4_prga dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rdy      (rdy),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren),
    .ct_addr  (ct_addr),
    .ct_rddata(ct_rddata),
    .pt_addr  (pt_addr),
    .pt_wrdata(pt_wrdata),
    .pt_wren  (pt_wren)
  );

  // Synchronous memories; load copies s_init into S and scrubs pt
  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (load) begin
      for (int n = 0; n < 256; n++) begin
        s_mem[n]  <= s_init[n];
        pt_mem[n] <= 8'h5A;
      end
      s_wr_cnt  <= 0;
      pt_wr_cnt <= 0;
    end else begin
      if (s_wren) begin
        s_mem[s_addr] <= s_wrdata;
        s_wr_cnt      <= s_wr_cnt + 1;
      end
      if (pt_wren) begin
        pt_mem[pt_addr] <= pt_wrdata;
        pt_wr_cnt       <= pt_wr_cnt + 1;
      end
    end
  end

  task automatic load_mems();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic set_identity();
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
  endtask

  task automatic set_random_perm();
    logic [7:0] t;
    int r;
    set_identity();
    for (int n = 255; n > 0; n--) begin
      r = $urandom_range(n, 0);
      t = s_init[n]; s_init[n] = s_init[r]; s_init[r] = t;
    end
  endtask

  task automatic set_ct(input int len);
    ct_mem[0] = 8'(len);
    for (int n = 1; n < 256; n++) ct_mem[n] = 8'($urandom);
  endtask

  // Textbook RC4 PRGA over the length-prefixed message
  function automatic void model();
    logic [7:0] s[256];
    logic [7:0] i, j, t;
    int len;
    len = int'(ct_mem[0]);
    for (int n = 0; n < 256; n++) s[n] = s_init[n];
    i = 0; j = 0;
    exp_pt[0] = ct_mem[0];
    for (int k = 1; k <= len; k++) begin
      i = i + 1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_pt[k] = ct_mem[k] ^ s[8'(s[i] + s[j])];
    end
    for (int n = 0; n < 256; n++) exp_s[n] = s[n];
  endfunction

  // Accepts en, then counts edges until rdy returns; optionally re-pulses en while busy
  task automatic run(output int cycles, input int busy_at);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    cycles = 0;
    while (!rdy && cycles < 5000) begin
      @(posedge clk); #1;
      cycles++;
      en = (cycles == busy_at);
    end
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    set_identity(); set_ct(0);
    load_mems();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    vectors++;
    if (rdy !== 1'b1) begin
      miscompares++; $display("FAIL reset_rdy: got %b want 1", rdy);
    end
    vectors++;
    if ({s_wren, pt_wren, s_addr, ct_addr, pt_addr, s_wrdata, pt_wrdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got s_wren=%b pt_wren=%b s_addr=%h ct_addr=%h pt_addr=%h want all 0",
               s_wren, pt_wren, s_addr, ct_addr, pt_addr);
    end
  endtask

  task automatic test_len0();
    int cycles;
    set_identity(); set_ct(0);
    load_mems();
    run(cycles, -1);
    vectors++;
    if (cycles !== 2) begin
      miscompares++; $display("FAIL len0_latency: got %0d want 2", cycles);
    end
    vectors++;
    if (pt_wr_cnt !== 1 || pt_mem[0] !== 8'h00) begin
      miscompares++;
      $display("FAIL len0_pt: got %0d writes pt[0]=%h want 1 write pt[0]=00", pt_wr_cnt, pt_mem[0]);
    end
    vectors++;
    if (s_wr_cnt !== 0) begin
      miscompares++; $display("FAIL len0_s_writes: got %0d want 0", s_wr_cnt);
    end
  endtask

  task automatic test_identity(input int busy_at);
    logic [7:0] want[4];
    int cycles;
    want = '{8'h03, 8'hA8, 8'hBE, 8'hCB};
    set_identity();
    set_ct(0);
    ct_mem[0] = 8'h03; ct_mem[1] = 8'hAA; ct_mem[2] = 8'hBB; ct_mem[3] = 8'hCC;
    load_mems();
    run(cycles, busy_at);
    vectors++;
    if (cycles !== 20) begin
      miscompares++; $display("FAIL identity_latency(busy=%0d): got %0d want 20", busy_at, cycles);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (pt_mem[k] !== want[k]) begin
        miscompares++;
        $display("FAIL identity_pt[%0d](busy=%0d): got %h want %h", k, busy_at, pt_mem[k], want[k]);
      end
    end
    for (int n = 0; n < 256; n++) begin
      logic [7:0] w;
      w = (n == 2) ? 8'h03 : (n == 3) ? 8'h05 : (n == 5) ? 8'h02 : 8'(n);
      vectors++;
      if (s_mem[n] !== w) begin
        miscompares++;
        $display("FAIL identity_s[%0d](busy=%0d): got %h want %h", n, busy_at, s_mem[n], w);
      end
    end
    vectors++;
    if (pt_wr_cnt !== 4 || s_wr_cnt !== 6) begin
      miscompares++;
      $display("FAIL identity_write_counts: got pt=%0d s=%0d want pt=4 s=6", pt_wr_cnt, s_wr_cnt);
    end
  endtask

  task automatic test_wrap();
    int cycles;
    for (int n = 0; n < 256; n++) s_init[n] = 8'hFF;
    set_ct(1);
    ct_mem[1] = 8'h00;
    load_mems();
    run(cycles, -1);
    vectors++;
    if (cycles !== 8) begin
      miscompares++; $display("FAIL wrap_latency: got %0d want 8", cycles);
    end
    vectors++;
    if (pt_mem[0] !== 8'h01 || pt_mem[1] !== 8'hFF) begin
      miscompares++;
      $display("FAIL wrap_pt: got %h %h want 01 ff", pt_mem[0], pt_mem[1]);
    end
    for (int n = 0; n < 256; n++) begin
      vectors++;
      if (s_mem[n] !== 8'hFF) begin
        miscompares++; $display("FAIL wrap_s[%0d]: got %h want ff", n, s_mem[n]);
      end
    end
  endtask

  task automatic test_random_messages(input int iters, input int max_len);
    int cycles, len;
    for (int it = 0; it < iters; it++) begin
      len = (max_len == 255) ? 255 : $urandom_range(max_len, 1);
      set_random_perm(); set_ct(len);
      model();
      load_mems();
      run(cycles, -1);
      vectors++;
      if (cycles !== 2 + 6 * len) begin
        miscompares++;
        $display("FAIL random_latency(L=%0d): got %0d want %0d", len, cycles, 2 + 6 * len);
      end
      for (int k = 0; k <= len; k++) begin
        vectors++;
        if (pt_mem[k] !== exp_pt[k]) begin
          miscompares++;
          $display("FAIL random_pt[%0d](L=%0d): got %h want %h", k, len, pt_mem[k], exp_pt[k]);
        end
      end
      for (int n = 0; n < 256; n++) begin
        vectors++;
        if (s_mem[n] !== exp_s[n]) begin
          miscompares++;
          $display("FAIL random_s[%0d](L=%0d): got %h want %h", n, len, s_mem[n], exp_s[n]);
        end
      end
      vectors++;
      if (pt_wr_cnt !== len + 1 || s_wr_cnt !== 2 * len) begin
        miscompares++;
        $display("FAIL random_write_counts(L=%0d): got pt=%0d s=%0d want pt=%0d s=%0d",
                 len, pt_wr_cnt, s_wr_cnt, len + 1, 2 * len);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    set_random_perm(); set_ct(3);
    load_mems();
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++;
    if (rdy !== 1'b1 || s_wren !== 1'b0 || pt_wren !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: got rdy=%b s_wren=%b pt_wren=%b want 1 0 0", rdy, s_wren, pt_wren);
    end
    set_random_perm(); set_ct(10);
    model();
    load_mems();
    run(cycles, -1);
    vectors++;
    if (cycles !== 62) begin
      miscompares++; $display("FAIL reset_mid_latency: got %0d want 62", cycles);
    end
    for (int k = 0; k <= 10; k++) begin
      vectors++;
      if (pt_mem[k] !== exp_pt[k]) begin
        miscompares++;
        $display("FAIL reset_mid_pt[%0d]: got %h want %h", k, pt_mem[k], exp_pt[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_len0();
    test_identity(-1);
    test_identity(7);
    test_wrap();
    test_random_messages(6, 40);
    test_reset_mid();
    test_random_messages(1, 255);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arc4_prga.md
Name: arc4_prga

Overview:
- Pseudo-random generation stage of the ARC4 decryption unit. Sits directly downstream of the key-scheduling stage.
- Once the S array has been scheduled, it walks S, generates one keystream byte per message byte, and XORs it with the ciphertext.
- Writes the plaintext into the plaintext memory and swaps entries of S in place.
- Ciphertext and plaintext are length-prefixed: byte 0 holds the length L (0..255); bytes 1..L hold the data.

Parameters:
None.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
en  in  1  start request; accepted only when rdy=1
rdy  out  1  1 = idle and able to accept en
s_addr  out  8  S memory address
s_rddata  in  8  S memory read data, valid one cycle after address
s_wrdata  out  8  S memory write data
s_wren  out  1  S memory write enable
ct_addr  out  8  ciphertext memory address (read-only)
ct_rddata  in  8  ciphertext read data, valid one cycle after address
pt_addr  out  8  plaintext memory address
pt_wrdata  out  8  plaintext write data
pt_wren  out  1  plaintext write enable

Behaviour:
- Memories: synchronous, 1-cycle read latency, write on clk edge when wren=1. A read issued the cycle after a write returns the new data.
- Registers: i, j, k (message index), len, si, sj (all 8-bit). All arithmetic is mod 256.
- rdy = 1 exactly when state == IDLE. Other outputs are combinational from state/registers.
- Default outputs (IDLE and any state not listed below): all addresses 0, all wrdata 0, all wren 0.
- Reset (rst_n=0 at posedge): state <- IDLE, i=j=k=len=0. rdy=1 from the following cycle.
- Reset mid-operation aborts immediately. Partially written S and pt contents are undefined; there is no write in the cycle after reset.
- en while rdy=0 is ignored (no restart).
- States and transitions:
  - IDLE: on en=1 -> RD_LEN; i<=0, j<=0, k<=1.
  - RD_LEN: ct_addr=0 -> WR_LEN.
  - WR_LEN: len<=ct_rddata; pt_addr=0, pt_wrdata=ct_rddata, pt_wren=1. If ct_rddata==0 -> IDLE, else -> INC_I.
  - INC_I: i<=i+1; s_addr=i+1 -> RD_SI.
  - RD_SI: si<=s_rddata; j<=j+s_rddata; s_addr=j+s_rddata -> RD_SJ.
  - RD_SJ: sj<=s_rddata; s_addr=i, s_wrdata=s_rddata, s_wren=1 -> WR_SJ.
  - WR_SJ: s_addr=j, s_wrdata=si, s_wren=1 -> RD_PAD.
  - RD_PAD: s_addr=si+sj, ct_addr=k -> XOR.
  - XOR: pt_addr=k, pt_wrdata=s_rddata^ct_rddata, pt_wren=1. If k==len -> IDLE, else k<=k+1 and -> INC_I.
- Latency: en is accepted at edge T. rdy returns high at edge T+2+6L.
  - L=0: exactly one write, pt[0]=0, and no S access.
- Boundary cases:
  - i==j: both swap writes go to the same address with the same value, so S is unchanged.
  - j and si+sj wrap modulo 256.
  - L=255: k ends at 255, and i reaches 255 without wrapping.

Test Plan:
- Length 0: ct[0]=00, en pulse -> exactly one pt write (addr 0, data 00); no s_wren; rdy high 2 cycles after accept.
- Identity S: S[n]=n for all n, ct="\x03 AA BB CC".
  - pt = 03, A8, BE, CB (pads 02, 05, 07).
  - Afterwards S[2]=03, S[3]=05, S[5]=02; all other entries unchanged.
  - rdy returns 20 cycles after accept.
- Wrap: S all FF, ct[0]=01, ct[1]=00 -> j=FF, pad index FE, pt[1]=FF; S unchanged.
- Busy: en re-pulsed mid-message -> ignored; output identical to the identity-S test; rdy stays 0 until done.
- Reset mid-message: assert rst_n=0 during RD_SJ.
  - No writes in the cycle after reset; rdy=1.
  - A new en then decrypts correctly from ct[0] on freshly loaded S.
- Max length: ct[0]=FF with a reference-model comparison of all 255 bytes; rdy returns after 1532 cycles.
